// File: rtl/cf_fft_pkg.sv
// cf_fft_pkg: shared defaults, types and helpers for the streaming FFT datapath.
package cf_fft_pkg;

    localparam int N_LOG2_DEF = 10;
    localparam int DW_DEF     = 16;
    localparam int BR_W       = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [DW_DEF-1:0] re;
        logic [DW_DEF-1:0] im;
    } sample_t;

    // Reverses the low w bits of v; bits at and above w return as zero.
    function automatic logic [BR_W-1:0] bitrev(input logic [BR_W-1:0] v,
                                               input int w);
        logic [BR_W-1:0] r;
        logic [BR_W-1:0] s;
        r = '0;
        s = v;
        for (int i = 0; i < BR_W; i++) begin
            if (i < w) begin
                r = {r[BR_W-2:0], s[0]};
                s = s >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cf_fft_1024_8_reorder_ram.sv
// cf_fft_1024_8_reorder_ram: simple dual-port RAM, one write port and
// one registered read port sharing a clock enable.
module cf_fft_1024_8_reorder_ram #(
    parameter int AW = 11,
    parameter int W  = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ce_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [2**AW];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (ce_i && we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is reset; the array keeps its contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (ce_i && re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cf_fft_1024_8_reorder.sv
// cf_fft_1024_8_reorder: ping-pong buffer turning bit-reversed FFT frames
// into natural-order frames with start pulse and valid flag.
module cf_fft_1024_8_reorder
    import cf_fft_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic          clock_c,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          in_sync,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_sync,
    output logic          out_valid,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im
);

    localparam int AW = N_LOG2 + 1;

    state_e            state_q;
    logic [N_LOG2-1:0] k_q;
    logic              wb_q;
    logic [1:0]        full_q;
    logic              sync_q;
    logic              valid_q;

    logic              rd_full;
    logic              early;
    logic              we;
    logic [N_LOG2-1:0] w_idx;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr;
    logic [2*DW-1:0]   rdata;

    assign rd_full = full_q[~wb_q];
    assign early   = (state_q == ST_RUN) && in_sync && (k_q != '0);
    assign we      = (state_q == ST_RUN) || in_sync;
    // A resync sample always lands on index 0 of the current write bank.
    assign w_idx   = early ? '0 : N_LOG2'(bitrev(BR_W'(k_q), N_LOG2));
    assign waddr   = {wb_q, w_idx};
    assign raddr   = {~wb_q, k_q};

    cf_fft_1024_8_reorder_ram #(
        .AW (AW),
        .W  (2*DW)
    ) u_ram (
        .clk_i   (clock_c),
        .rst_ni  (reset_n),
        .ce_i    (ce),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i ({in_re, in_im}),
        .re_i    (rd_full),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_ff @(posedge clock_c or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            wb_q    <= 1'b0;
            full_q  <= '0;
            sync_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (ce) begin
            valid_q <= rd_full;
            sync_q  <= rd_full && (k_q == '0);
            unique case (state_q)
                ST_IDLE: begin
                    if (in_sync) begin
                        state_q      <= ST_RUN;
                        k_q          <= N_LOG2'(1);
                        full_q[wb_q] <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (early) begin
                        k_q    <= N_LOG2'(1);
                        full_q <= '0;
                    end else if (&k_q) begin
                        full_q[wb_q] <= 1'b1;
                        wb_q         <= ~wb_q;
                        k_q          <= '0;
                    end else begin
                        if (k_q == '0) begin
                            full_q[wb_q] <= 1'b0;
                        end
                        k_q <= k_q + N_LOG2'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_sync  = sync_q;
    assign out_valid = valid_q;
    assign out_re    = rdata[2*DW-1:DW];
    assign out_im    = rdata[DW-1:0];

endmodule

// File: tb/tb_cf_fft_1024_8_reorder.sv
// tb_cf_fft_1024_8_reorder: table/scoreboard bench for the reorder buffer,
// N_LOG2=3 instance for frame sequencing, N_LOG2=10 instance for full order.
module tb_cf_fft_1024_8_reorder;
    import cf_fft_pkg::*;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        ce      = 1'b0;
    logic        in_sync = 1'b0;
    logic [15:0] in_re   = '0;
    logic [15:0] in_im   = '0;

    logic        o8_sync, o8_valid;
    logic [15:0] o8_re, o8_im;
    logic        ok_sync, ok_valid;
    logic [15:0] ok_re, ok_im;

    always #5 clk = ~clk;

    cf_fft_1024_8_reorder #(.N_LOG2(3), .DW(16)) u_dut8 (
        .clock_c   (clk),
        .reset_n   (rst_n),
        .ce        (ce),
        .in_sync   (in_sync),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_sync  (o8_sync),
        .out_valid (o8_valid),
        .out_re    (o8_re),
        .out_im    (o8_im)
    );

    cf_fft_1024_8_reorder #(.N_LOG2(10), .DW(16)) u_dut1k (
        .clock_c   (clk),
        .reset_n   (rst_n),
        .ce        (ce),
        .in_sync   (in_sync),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_sync  (ok_sync),
        .out_valid (ok_valid),
        .out_re    (ok_re),
        .out_im    (ok_im)
    );

    typedef struct {
        logic        sync;
        logic [15:0] re;
        logic [15:0] exp_re;
        logic        exp_sync;
    } vec_t;

    typedef struct {
        sample_t s;
        logic    sync;
        int      at;
    } exp_t;

    vec_t        tbl [40];
    exp_t        q [$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          en_cnt   = 0;
    int          e0       = 0;
    bit          en_edge  = 1'b0;
    bit          mon_on   = 1'b0;
    logic        p_sync   = 1'b0;
    logic        p_valid  = 1'b0;
    logic [15:0] p_re     = '0;
    logic [15:0] p_im     = '0;

    function automatic int brev(input int v, input int w);
        int r = 0;
        for (int b = 0; b < w; b++) begin
            if ((v >> b) & 1) r |= 1 << (w - 1 - b);
        end
        return r;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act,
                            input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // One accepted sample; with gated=1, ce is randomised until an enabled edge.
    task automatic send(input bit s, input logic [15:0] re,
                        input logic [15:0] im, input bit gated);
        bit done = 1'b0;
        in_sync = s;
        in_re   = re;
        in_im   = im;
        while (!done) begin
            ce = gated ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            en_edge = ce;
            if (ce) en_cnt++;
            done = ce;
            #1;
        end
    endtask

    task automatic push_exp(input int re, input bit s, input int at);
        exp_t e;
        e.s.re = 16'(re);
        e.s.im = 16'(re) ^ 16'h5A5A;
        e.sync = s;
        e.at   = at;
        q.push_back(e);
    endtask

    task automatic send_frame(input int base, input bit fsync, input bit resync);
        int f0 = 0;
        for (int j = 0; j < 8; j++) begin
            send(fsync && (j == 0), 16'(base + j), 16'(base + j) ^ 16'h5A5A, 1'b0);
            if (j == 0) begin
                f0 = en_cnt;
                if (resync) begin
                    while (q.size() > 0 && q[$].at > f0) void'(q.pop_back());
                end
            end
            if (resync && j == 2) check_eq("resync_drop", {o8_valid, o8_sync}, 2'b00);
        end
        for (int n = 0; n < 8; n++) push_exp(base + brev(n, 3), n == 0, f0 + 8 + n);
    endtask

    // Scoreboard monitor for the N=8 instance.
    always @(negedge clk) begin
        if (mon_on && rst_n) begin
            if (en_edge) begin
                while (q.size() > 0 && q[0].at < en_cnt) begin
                    check_eq("missing_out", 64'(en_cnt), 64'(q[0].at));
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].at == en_cnt) begin
                    mon_e = q.pop_front();
                    check_eq("out8", {o8_valid, o8_sync, o8_re, o8_im},
                             {1'b1, mon_e.sync, mon_e.s});
                end else begin
                    check_eq("idle8", {o8_valid, o8_sync}, 2'b00);
                end
            end else begin
                check_eq("hold8", {o8_valid, o8_sync, o8_re, o8_im},
                         {p_valid, p_sync, p_re, p_im});
            end
        end
        p_valid = o8_valid;
        p_sync  = o8_sync;
        p_re    = o8_re;
        p_im    = o8_im;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=done", $time);
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 40; r++) begin
            tbl[r].sync     = (r < 24) && (r % 8 == 0);
            tbl[r].re       = 16'(r);
            tbl[r].exp_re   = 16'(8 * (r / 8) + brev(r % 8, 3));
            tbl[r].exp_sync = (r % 8 == 0);
        end

        #1 rst_n = 1'b0;
        #1;
        check_eq("reset8", {o8_valid, o8_sync, o8_re, o8_im}, '0);
        check_eq("reset1k", {ok_valid, ok_sync, ok_re, ok_im}, '0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        mon_on = 1'b1;

        for (int i = 0; i < 20; i++) begin
            send(1'b0, 16'($urandom), 16'($urandom), 1'b0);
            check_eq("idle_out", {o8_valid, o8_sync, o8_re}, '0);
        end

        // Frames 0..2 ungated with in_sync, frames 3..4 free-running with ce gated.
        for (int r = 0; r < 40; r++) begin
            send(tbl[r].sync, tbl[r].re, tbl[r].re ^ 16'h5A5A, r >= 24);
            if (r % 8 == 0) e0 = en_cnt;
            if (r % 8 == 7) begin
                for (int n = 0; n < 8; n++) begin
                    push_exp(int'(tbl[r - 7 + n].exp_re), tbl[r - 7 + n].exp_sync,
                             e0 + 8 + n);
                end
            end
        end

        send_frame(40, 1'b1, 1'b0);
        for (int j = 0; j < 5; j++) begin
            send(j == 0, 16'(48 + j), 16'(48 + j) ^ 16'h5A5A, 1'b0);
        end
        send_frame(100, 1'b1, 1'b1);
        send_frame(200, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            send(1'b0, 16'(300 + j), 16'(300 + j) ^ 16'h5A5A, 1'b0);
        end
        check_eq("pre_reset_valid", {o8_valid}, 1'b1);

        #1 rst_n = 1'b0;
        mon_on = 1'b0;
        #1;
        check_eq("async_reset8", {o8_valid, o8_sync, o8_re, o8_im}, '0);
        check_eq("async_reset1k", {ok_valid, ok_sync, ok_re, ok_im}, '0);
        q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        en_edge = 1'b0;
        mon_on  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(1'b0, 16'($urandom), 16'($urandom), 1'b0);
            check_eq("post_reset_idle", {o8_valid, o8_sync}, 2'b00);
        end

        mon_on = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            logic [15:0] v;
            v = (i < 1024) ? 16'(i) : 16'hAAAA;
            send(i == 0, v, ~v, 1'b0);
            if (i < 1024) begin
                check_eq("fill1k", {ok_valid, ok_sync}, 2'b00);
            end else begin
                logic [15:0] x;
                x = 16'(brev(i - 1024, 10));
                check_eq("ramp1k", {ok_valid, ok_sync, ok_re, ok_im},
                         {1'b1, (i == 1024), x, ~x});
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
